// File: rtl/aes_128_inv_subbytes.sv
// aes_128_inv_subbytes: decrypt-side InvShiftRows + InvSubBytes stage.
// A 128-bit state is captured, then looked up one 4-byte output column per
// cycle through two dual-port inverse S-box ROMs. Results are held in an
// output register until the consumer takes them.

// Dual-port inverse S-box ROM with registered read data, cleared by clr.
module aes_128_inv_sbox (
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] addr_a,
   input  logic [7:0] addr_b,
   output logic [7:0] data_a,
   output logic [7:0] data_b
);

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Registered lookup on both ports; clr forces the read registers to zero.
   always_ff @(posedge clk) begin
      if (clr) begin
         data_a <= 8'h00;
         data_b <= 8'h00;
      end else begin
         data_a <= INV_SBOX[addr_a];
         data_b <= INV_SBOX[addr_b];
      end
   end

endmodule

module aes_128_inv_subbytes (
   input  logic         clk,
   input  logic         kill,
   input  logic [127:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [127:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state_reg;
   logic [1:0]     col_reg;
   logic [127:0]   cap_reg;
   logic [127:0]   out_reg;

   logic [7:0]     rom_addr [4];
   logic [7:0]     rom_data [4];
   logic [1:0]     wr_col;

   // Row r of output column col comes from input column (col - r) mod 4;
   // the 2-bit subtraction provides the wrap for free.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_addr
         localparam logic [1:0] ROW = 2'(gi);
         logic [1:0] src_col;
         assign src_col      = col_reg - ROW;
         assign rom_addr[gi] = cap_reg[{src_col, ROW, 3'b000} +: 8];
      end
   endgenerate

   // Two ROMs, two ports each: rows 0/1 on the first, rows 2/3 on the second.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rom
         aes_128_inv_sbox u_rom (
            .clk    (clk),
            .clr    (kill),
            .addr_a (rom_addr[2*gi]),
            .addr_b (rom_addr[2*gi+1]),
            .data_a (rom_data[2*gi]),
            .data_b (rom_data[2*gi+1])
         );
      end
   endgenerate

   // ROM data lags the address by one cycle, so it belongs to column col-1.
   // In DRAIN col has already wrapped to 0, which makes this column 3.
   assign wr_col = col_reg - 2'd1;

   // Control FSM, input capture and output column writes.
   always_ff @(posedge clk) begin
      if (kill) begin
         state_reg <= IDLE;
         col_reg   <= 2'd0;
         out_reg   <= 128'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  cap_reg   <= in_data;
                  col_reg   <= 2'd0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               col_reg <= col_reg + 2'd1;
               if (col_reg != 2'd0) begin
                  for (int r = 0; r < 4; r++) begin
                     out_reg[{wr_col, 2'(r), 3'b000} +: 8] <= rom_data[r];
                  end
               end
               if (col_reg == 2'd3) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               for (int r = 0; r < 4; r++) begin
                  out_reg[{wr_col, 2'(r), 3'b000} +: 8] <= rom_data[r];
               end
               state_reg <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign out_data  = out_reg;

endmodule

// File: tb/tb_aes_128_inv_subbytes.sv
// Testbench for aes_128_inv_subbytes: directed vector table, backpressure and
// kill sequences, then randomized blocks against a GF(2^8)-derived model.
module tb_aes_128_inv_subbytes;

   logic         clk = 1'b0;
   logic         kill;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   inv_tab [256];
   logic [127:0] exp_q [$];

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
      string        name;
   } vec_t;

   vec_t vecs [5];

   aes_128_inv_subbytes dut (
      .clk       (clk),
      .kill      (kill),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // GF(2^8) multiply with the AES polynomial
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   // Forward S-box from its definition, then invert it into inv_tab.
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_model(input logic [127:0] x);
      logic [127:0] y = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            y[8*(4*c+r) +: 8] = inv_tab[x[8*(4*((c - r + 4) % 4) + r) +: 8]];
         end
      end
      return y;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One block through the stage with out_ready asserted at cycle 6.
   task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] req);
      int waited = 0;
      logic [127:0] got;
      while (!in_ready && waited < 20) begin
         step();
         waited++;
      end
      check({name, " in_ready before accept"}, 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = din;
      step();                         // accept edge; now in cycle 1
      in_valid = 1'b0;
      in_data  = rand128();
      repeat (4) step();              // cycle 5
      check({name, " out_valid cycle 5"}, 128'(out_valid), 128'd0);
      step();                         // cycle 6
      check({name, " out_valid cycle 6"}, 128'(out_valid), 128'd1);
      check({name, " out_data"}, out_data, req);
      got = out_data;
      out_ready = 1'b1;
      step();                         // cycle 7
      out_ready = 1'b0;
      check({name, " in_ready cycle 7"}, 128'(in_ready), 128'd1);
      check({name, " out_valid cycle 7"}, 128'(out_valid), 128'd0);
      $display("block %s: in %h out %h", name, din, got);
   endtask

   initial begin
      logic [127:0] blk_a;
      logic [127:0] blk_c;

      build_tables();

      vecs[0].din = {16{8'h63}};
      vecs[0].dout = 128'h0;
      vecs[0].name = "all_63";
      vecs[1].din = {16{8'h00}};
      vecs[1].dout = {16{8'h52}};
      vecs[1].name = "all_00";
      vecs[2].din = 128'h63637c63_63636363_63636363_63636363;
      vecs[2].dout = 128'h00000000_00000000_00000000_00000100;
      vecs[2].name = "pos_byte13";
      vecs[3].din = 128'h63636363_63636363_7c636363_63636363;
      vecs[3].dout = 128'h00000000_00000000_00000000_01000000;
      vecs[3].name = "pos_byte7";
      vecs[4].din = 128'h63636363_63636363_63636363_75766416;
      vecs[4].dout = 128'h3f000000_000f0000_00008c00_000000ff;
      vecs[4].name = "value_sweep";

      kill      = 1'b1;
      in_valid  = 1'b0;
      in_data   = 128'd0;
      out_ready = 1'b0;
      step();
      step();
      check("reset in_ready", 128'(in_ready), 128'd1);
      check("reset out_valid", 128'(out_valid), 128'd0);
      check("reset out_data", out_data, 128'd0);
      kill = 1'b0;
      step();

      // Directed vector table
      for (int i = 0; i < 5; i++) begin
         run_block(vecs[i].name, vecs[i].din, vecs[i].dout);
      end

      // Backpressure: hold out_ready low for 10 cycles while in_valid stays high
      blk_a    = rand128();
      in_valid = 1'b1;
      in_data  = blk_a;
      step();                         // cycle 1
      for (int i = 0; i < 5; i++) begin
         in_data = rand128();
         step();
      end                             // cycle 6
      check("bp out_valid cycle 6", 128'(out_valid), 128'd1);
      check("bp out_data cycle 6", out_data, ref_model(blk_a));
      for (int i = 0; i < 10; i++) begin
         in_data = rand128();
         step();
         check("bp hold out_valid", 128'(out_valid), 128'd1);
         check("bp hold out_data", out_data, ref_model(blk_a));
         check("bp hold in_ready", 128'(in_ready), 128'd0);
      end
      $display("block backpressure_a: in %h held 10 cycles", blk_a);
      out_ready = 1'b1;
      in_data   = rand128();
      step();                         // back in IDLE
      out_ready = 1'b0;
      blk_c     = rand128();
      in_data   = blk_c;
      check("bp release in_ready", 128'(in_ready), 128'd1);
      step();                         // blk_c accepted; cycle 1
      for (int i = 0; i < 5; i++) begin
         in_data = rand128();
         step();
      end                             // cycle 6
      in_valid = 1'b0;
      check("bp next out_valid", 128'(out_valid), 128'd1);
      check("bp next out_data", out_data, ref_model(blk_c));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      $display("block backpressure_c: in %h out %h", blk_c, ref_model(blk_c));

      // kill mid-RUN (cycle 3)
      in_valid = 1'b1;
      in_data  = rand128();
      step();                         // cycle 1
      in_valid = 1'b0;
      step();                         // cycle 2
      step();                         // cycle 3
      kill = 1'b1;
      step();                         // cycle 4
      kill = 1'b0;
      check("kill out_valid", 128'(out_valid), 128'd0);
      check("kill out_data", out_data, 128'd0);
      check("kill in_ready", 128'(in_ready), 128'd1);
      run_block("after_kill", {16{8'h63}}, 128'd0);

      // kill together with an in_valid handshake: not accepted
      kill     = 1'b1;
      in_valid = 1'b1;
      in_data  = rand128();
      step();
      kill     = 1'b0;
      in_valid = 1'b0;
      check("kill+valid in_ready", 128'(in_ready), 128'd1);
      repeat (6) step();
      check("kill+valid no output", 128'(out_valid), 128'd0);
      $display("block kill_with_valid: discarded");

      // Randomized blocks with gaps on both sides
      fork
         begin : producer
            for (int n = 0; n < 1000; n++) begin
               logic [127:0] din;
               int  waited;
               logic acc;
               in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) step();
               din      = rand128();
               in_valid = 1'b1;
               in_data  = din;
               waited   = 0;
               acc      = 1'b0;
               while (!acc && waited < 60) begin
                  acc = in_ready;
                  if (acc) exp_q.push_back(ref_model(din));
                  step();
                  waited++;
               end
               if (!acc) begin
                  check("rand accept timeout", 128'd0, 128'd1);
                  break;
               end
            end
            in_valid = 1'b0;
         end
         begin : consumer
            int got = 0;
            int cyc = 0;
            while (got < 1000 && cyc < 30000) begin
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL rand unexpected output: got %h, required none", out_data);
                  end else begin
                     logic [127:0] req;
                     req = exp_q.pop_front();
                     check("rand out_data", out_data, req);
                     $display("rand block %0d: out %h", got, out_data);
                  end
                  got++;
               end
               step();
               cyc++;
            end
            out_ready = 1'b0;
            check("rand blocks received", 128'(got), 128'd1000);
         end
      join
      check("rand leftover expected", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
